// File: rtl/memory_tdpram_if.sv
// memory_tdpram_if -- port bundle for the true dual-port RAM.
//
// Groups the per-port control, address, data and output-stage enable
// signals of both RAM ports. The clock and reset are not part of the bundle.
//   master : driver side (the client issuing reads/writes)
//   slave  : the RAM itself
// Signals (per port X = a/b):
//   enX     port enable; an access starts only when high
//   weX     per-byte write enable (LANES bits); all-zero means read
//   addrX   word address
//   dinX    write data
//   regceX  clock enable of the final output stage (latency-2 ports only)
//   doutX   registered read data
interface memory_tdpram_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 64,
  parameter int BYTE_WIDTH = 8
);
  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;

  logic                  ena;
  logic [LANES-1:0]      wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic                  regcea;
  logic [DATA_WIDTH-1:0] douta;

  logic                  enb;
  logic [LANES-1:0]      web;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] dinb;
  logic                  regceb;
  logic [DATA_WIDTH-1:0] doutb;

  modport master (
    output ena, wea, addra, dina, regcea,
    output enb, web, addrb, dinb, regceb,
    input  douta, doutb
  );

  modport slave (
    input  ena, wea, addra, dina, regcea,
    input  enb, web, addrb, dinb, regceb,
    output douta, doutb
  );
endinterface

// File: rtl/memory_tdpram.sv
// memory_tdpram -- true dual-port RAM, byte write enables, no_change read mode.
//
// Two fully independent ports share one word array on a single clock.
// Each port writes the enabled byte lanes when enX=1 and weX!=0, and reads
// into its stage-1 register when enX=1 and weX=0. Writes and idle cycles
// leave stage 1 untouched. A latency-2 port adds a stage-2 register that
// loads only when regceX=1. Reset clears only the read pipeline registers;
// the memory array is never reset.
//
// Ports:
//   clk_i  in  clock for both ports
//   rst_i  in  async active-high reset of the read output registers
//   bus    memory_tdpram_if.slave : ena/wea/addra/dina/regcea/douta and
//          the matching port-B signals
//
// Configuration macro:
//   MEM_ZERO_INIT_EN  when defined, every memory word is 0 at time zero;
//                     otherwise contents are unspecified until written.
//
// Collisions: when both ports write the same word, port A wins on shared
// lanes. A port reading a word the other port is writing returns old data.
module memory_tdpram #(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 64,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY_A = 2,
  parameter int READ_LATENCY_B = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  memory_tdpram_if.slave        bus
);
  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef MEM_ZERO_INIT_EN
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: {DATA_WIDTH{1'b0}}};
`else
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
`endif

  logic [DATA_WIDTH-1:0] s1a_q, s1a_d, s2a_q, s2a_d;
  logic [DATA_WIDTH-1:0] s1b_q, s1b_d, s2b_q, s2b_d;

  // Memory array write; port B is applied first so port A overrides shared lanes.
  always_ff @(posedge clk_i) begin
    if (bus.enb) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.web[i]) begin
          mem_q[bus.addrb][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
    if (bus.ena) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.wea[i]) begin
          mem_q[bus.addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Port A read pipeline next state: stage 1 loads only on reads, stage 2 on regcea.
  always_comb begin
    s1a_d = s1a_q;
    s2a_d = s2a_q;
    if (bus.ena && (bus.wea == {LANES{1'b0}})) begin
      s1a_d = mem_q[bus.addra];
    end else begin
      s1a_d = s1a_q;
    end
    if (bus.regcea) begin
      s2a_d = s1a_q;
    end else begin
      s2a_d = s2a_q;
    end
  end

  // Port B read pipeline next state: same structure as port A.
  always_comb begin
    s1b_d = s1b_q;
    s2b_d = s2b_q;
    if (bus.enb && (bus.web == {LANES{1'b0}})) begin
      s1b_d = mem_q[bus.addrb];
    end else begin
      s1b_d = s1b_q;
    end
    if (bus.regceb) begin
      s2b_d = s1b_q;
    end else begin
      s2b_d = s2b_q;
    end
  end

  // Read pipeline registers; reset discards any read in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1a_q <= {DATA_WIDTH{1'b0}};
      s2a_q <= {DATA_WIDTH{1'b0}};
      s1b_q <= {DATA_WIDTH{1'b0}};
      s2b_q <= {DATA_WIDTH{1'b0}};
    end else begin
      s1a_q <= s1a_d;
      s2a_q <= s2a_d;
      s1b_q <= s1b_d;
      s2b_q <= s2b_d;
    end
  end

  // Output selection by configured latency; both choices are registers.
  assign bus.douta = (READ_LATENCY_A == 2) ? s2a_q : s1a_q;
  assign bus.doutb = (READ_LATENCY_B == 2) ? s2b_q : s1b_q;

endmodule

// File: tb/tb_memory_tdpram.sv
// tb_memory_tdpram -- directed self-checking bench for memory_tdpram
// (default configuration: port A latency 2, port B latency 1).
// Inputs change 1 time unit after each rising edge; outputs are sampled
// at the same point, so each sample reflects the edge just taken.
module tb_memory_tdpram;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks_cnt = 0;
  int   fail_cnt   = 0;

  localparam logic [63:0] VAL5   = 64'h0123456789ABCDEF;
  localparam logic [63:0] VAL5B  = 64'h0123456789ABCDFF;
  localparam logic [63:0] VAL9   = 64'hBBBBBBBBAAAAAAAA;
  localparam logic [63:0] VAL7   = 64'h7777777777777777;

  always #5 clk = ~clk;

  memory_tdpram_if #(.ADDR_WIDTH(14), .DATA_WIDTH(64), .BYTE_WIDTH(8)) bus ();

  memory_tdpram #(
    .ADDR_WIDTH(14), .DATA_WIDTH(64), .BYTE_WIDTH(8),
    .READ_LATENCY_A(2), .READ_LATENCY_B(1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic port_a(input logic en, input logic [7:0] we, input logic [13:0] addr,
                        input logic [63:0] din, input logic regce);
    bus.ena = en; bus.wea = we; bus.addra = addr; bus.dina = din; bus.regcea = regce;
  endtask

  task automatic port_b(input logic en, input logic [7:0] we, input logic [13:0] addr,
                        input logic [63:0] din);
    bus.enb = en; bus.web = we; bus.addrb = addr; bus.dinb = din;
  endtask

  initial begin
    port_a(1'b0, 8'h00, 14'd0, 64'd0, 1'b0);
    port_b(1'b0, 8'h00, 14'd0, 64'd0);
    bus.regceb = 1'b0;  // latency-1 port: regceb must have no effect
    repeat (3) tick();
    check_eq("reset_douta", bus.douta, 64'd0);
    check_eq("reset_doutb", bus.doutb, 64'd0);
    rst = 1'b0;
    tick();

    // Port A full-word write, then latency-2 read
    port_a(1'b1, 8'hFF, 14'd5, VAL5, 1'b1);
    tick();
    port_a(1'b1, 8'h00, 14'd5, 64'd0, 1'b1);
    tick();
    check_eq("a_lat2_first_edge", bus.douta, 64'd0);
    port_a(1'b0, 8'h00, 14'd0, 64'd0, 1'b1);
    tick();
    check_eq("a_lat2_read5", bus.douta, VAL5);

    // Port B latency-1 read, no_change on write, byte-lane merge
    port_b(1'b1, 8'h00, 14'd5, 64'd0);
    tick();
    check_eq("b_lat1_read5", bus.doutb, VAL5);
    port_b(1'b1, 8'h01, 14'd5, 64'h00000000000000FF);
    tick();
    check_eq("b_nochange_write", bus.doutb, VAL5);
    port_b(1'b1, 8'h00, 14'd5, 64'd0);
    tick();
    check_eq("b_reread5_lane0", bus.doutb, VAL5B);

    // Write/write collision: A wins its lanes, B keeps the rest
    port_a(1'b1, 8'h0F, 14'd9, 64'hAAAAAAAAAAAAAAAA, 1'b1);
    port_b(1'b1, 8'hFF, 14'd9, 64'hBBBBBBBBBBBBBBBB);
    tick();
    port_a(1'b1, 8'h00, 14'd9, 64'd0, 1'b1);
    port_b(1'b1, 8'h00, 14'd9, 64'd0);
    tick();
    check_eq("b_collision9", bus.doutb, VAL9);
    port_a(1'b0, 8'h00, 14'd0, 64'd0, 1'b1);
    port_b(1'b0, 8'h00, 14'd0, 64'd0);
    tick();
    check_eq("a_collision9", bus.douta, VAL9);

    // Read-during-write from the other port returns old data
    port_a(1'b1, 8'hFF, 14'd3, 64'h22, 1'b1);
    tick();
    port_a(1'b1, 8'hFF, 14'd3, 64'h11, 1'b1);
    port_b(1'b1, 8'h00, 14'd3, 64'd0);
    tick();
    check_eq("b_rdw_old", bus.doutb, 64'h22);
    port_a(1'b0, 8'h00, 14'd0, 64'd0, 1'b1);
    tick();
    check_eq("b_rdw_new", bus.doutb, 64'h11);
    port_b(1'b0, 8'h00, 14'd0, 64'd0);
    tick();
    check_eq("b_idle_hold", bus.doutb, 64'h11);
    check_eq("a_idle_hold", bus.douta, VAL9);

    // regcea=0 on the second edge holds the old output
    port_a(1'b1, 8'h00, 14'd5, 64'd0, 1'b1);
    tick();
    port_a(1'b0, 8'h00, 14'd0, 64'd0, 1'b0);
    tick();
    check_eq("a_regce_hold", bus.douta, VAL9);
    port_a(1'b0, 8'h00, 14'd0, 64'd0, 1'b1);
    tick();
    check_eq("a_regce_release", bus.douta, VAL5B);

    // Reset mid-stream: outputs clear at once, in-flight read discarded
    port_a(1'b1, 8'h00, 14'd9, 64'd0, 1'b1);
    port_b(1'b1, 8'h00, 14'd3, 64'd0);
    tick();
    rst = 1'b1;
    #1;
    check_eq("rst_async_douta", bus.douta, 64'd0);
    check_eq("rst_async_doutb", bus.doutb, 64'd0);
    // write coincident with reset still lands
    port_a(1'b1, 8'hFF, 14'd7, VAL7, 1'b1);
    port_b(1'b0, 8'h00, 14'd0, 64'd0);
    tick();
    rst = 1'b0;
    port_a(1'b0, 8'h00, 14'd0, 64'd0, 1'b1);
    tick();
    check_eq("post_rst_douta", bus.douta, 64'd0);
    check_eq("post_rst_doutb", bus.doutb, 64'd0);

    // Memory preserved across reset
    port_b(1'b1, 8'h00, 14'd9, 64'd0);
    port_a(1'b1, 8'h00, 14'd7, 64'd0, 1'b1);
    tick();
    check_eq("b_reread9", bus.doutb, VAL9);
    port_b(1'b1, 8'h00, 14'd7, 64'd0);
    port_a(1'b0, 8'h00, 14'd0, 64'd0, 1'b1);
    tick();
    check_eq("a_write_during_rst", bus.douta, VAL7);
    check_eq("b_write_during_rst", bus.doutb, VAL7);
    port_b(1'b1, 8'h00, 14'd16383, 64'd0);
    port_b(1'b1, 8'h00, 14'd5, 64'd0);
    tick();
    check_eq("b_reread5", bus.doutb, VAL5B);

`ifdef MEM_ZERO_INIT_EN
    port_b(1'b1, 8'h00, 14'd100, 64'd0);
    tick();
    check_eq("b_zero_init", bus.doutb, 64'd0);
`endif

    port_a(1'b0, 8'h00, 14'd0, 64'd0, 1'b0);
    port_b(1'b0, 8'h00, 14'd0, 64'd0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/memory_tdpram.md
MEMORY_TDPRAM -- requirements
Module: memory_tdpram

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 14: word address width; depth = 2**ADDR_WIDTH words.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64: word width for both ports.
REQ-003 The block SHALL have parameter BYTE_WIDTH, default 8: bits per write-enable lane; lanes = DATA_WIDTH/BYTE_WIDTH.
REQ-004 The block SHALL have parameter READ_LATENCY_A, default 2 (legal values 1 and 2), and parameter READ_LATENCY_B, default 1 (legal values 1 and 2).
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i, in, 1: clock for both ports.
- rst_i, in, 1: async active-high reset of the read output registers.
- ena / enb, in, 1: port enable; a read or write starts only when high.
- wea / web, in, lanes: per-byte write enable.
- addra / addrb, in, ADDR_WIDTH: word address.
- dina / dinb, in, DATA_WIDTH: write data.
- regcea / regceb, in, 1: clock enable of the final output stage (latency-2 ports only).
- douta / doutb, out, DATA_WIDTH: registered read data.

Function
REQ-007 Each port SHALL perform a write when enX=1 and weX!=0: for each lane i with weX[i]=1, byte i of dinX goes to mem[addrX] at the clock edge; other lanes are unchanged.
REQ-008 Each port SHALL perform a read when enX=1 and weX=0: mem[addrX] is captured into stage-1 register at the edge.
REQ-009 In write-mode no_change, a write or idle cycle (enX=0) SHALL leave stage 1 unchanged.
REQ-010 For latency 1, doutX SHALL be stage 1, valid one edge after the read edge, and regceX SHALL be ignored.
REQ-011 For latency 2, stage 2 SHALL load stage 1 at each edge where regceX=1 and hold otherwise; doutX is stage 2, valid two edges after the read edge when regceX=1 on the second edge.
REQ-012 Both ports SHALL be fully independent; simultaneous reads at any addresses are legal.
REQ-013 Collision: when both ports write the same address in the same cycle, for each lane written by both ports, port A data SHALL win; lanes written by only one port take that port's data.
REQ-014 Read/write collision: when one port reads an address the other port writes in the same cycle, the reader SHALL return the old (pre-write) data.
REQ-015 Addresses SHALL be used unmodified, with no wrap logic beyond ADDR_WIDTH bits.

Reset
REQ-016 When rst_i=1, all stage-1 and stage-2 registers of both ports SHALL clear to 0 asynchronously, so douta=doutb=0 while reset is asserted.
REQ-017 Reset SHALL NOT alter memory contents; a write coincident with reset still occurs; a read pipeline in flight during reset is discarded.
REQ-018 After deassertion, outputs SHALL stay 0 until the next read result reaches them.

Configuration
REQ-019 With macro MEM_ZERO_INIT_EN defined, all memory words SHALL be 0 at time zero; without it, memory contents SHALL be unspecified (X in simulation) until written.

Verification
REQ-020 Port A write 0x0123456789ABCDEF to addr 5 (wea=0xFF); port A read addr 5 with regcea=1 -> douta=0x0123456789ABCDEF exactly 2 edges after the read edge.
REQ-021 Port B read addr 5 -> doutb=0x0123456789ABCDEF 1 edge after the read edge; then port B write addr 5 with web=0x01, dinb=0xFF -> doutb unchanged; re-read -> 0x0123456789ABCDFF.
REQ-022 Both ports write addr 9 in the same cycle (A: 0xAAAA.., wea=0x0F; B: 0xBBBB.., web=0xFF) -> mem[9]=0xBBBBBBBBAAAAAAAA.
REQ-023 Port A writes 0x11 to addr 3 (previously 0x22) while port B reads addr 3 in the same cycle -> doutb=0x22; next read -> 0x11.
REQ-024 Read latency-2 data with regcea=0 on the second edge -> douta holds its old value; assert rst_i mid-stream -> both outputs 0 immediately; memory is preserved on re-read.
REQ-025 With MEM_ZERO_INIT_EN defined, read an unwritten address -> 0.
